// File: rtl/hls_deadlock_reporter_if.sv
// Report-side bundle of the deadlock reporter: monitor block inputs, clear, and the valid/ready record.
interface hls_deadlock_reporter_if #(
  parameter int NUM_MON = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_MON-1:0] mon_block;
  logic               clear;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [ID_W-1:0]    rpt_id;
  logic [CNT_W-1:0]   rpt_cycles;
  logic               deadlock_flag;

  modport master (
    output mon_block, clear, rpt_ready,
    input  rpt_valid, rpt_id, rpt_cycles, deadlock_flag
  );

  modport slave (
    input  mon_block, clear, rpt_ready,
    output rpt_valid, rpt_id, rpt_cycles, deadlock_flag
  );
endinterface

// File: rtl/hls_deadlock_reporter.sv
// Confirms a monitor's block held for HOLD_CYCLES and emits one valid/ready record; sticky flag until clear.
// HLS_DEADLOCK_REPORT_ALL_EN: report every confirmed monitor once per clear instead of only the first.
module hls_deadlock_reporter #(
  parameter int NUM_MON     = 4,
  parameter int ID_W        = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input logic                  clock,
  input logic                  reset,
  hls_deadlock_reporter_if.slave bus
);
  localparam int            PW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] HOLD_V = PW'(HOLD_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REPORT, S_LATCHED} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   ts_q;
  logic [CNT_W-1:0]   rpt_cycles_q;
  logic [ID_W-1:0]    rpt_id_q;
  logic               rpt_valid_q;
  logic               flag_q;
  logic [PW-1:0]      cnt_q [NUM_MON];
  logic [PW-1:0]      cnt_d [NUM_MON];
  logic [NUM_MON-1:0] conf;
  logic [NUM_MON-1:0] cand;
  logic               clr_eff;

  function automatic logic [ID_W-1:0] lowest(input logic [NUM_MON-1:0] m);
    lowest = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (m[i]) lowest = ID_W'(i);
    end
  endfunction

  // clear is ignored while a record is outstanding
  assign clr_eff = bus.clear && (state_q != S_REPORT);

  always_comb begin
    conf = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      conf[i] = (cnt_q[i] == HOLD_V);
      if (clr_eff || !bus.mon_block[i]) cnt_d[i] = '0;
      else if (conf[i])                 cnt_d[i] = cnt_q[i];
      else                              cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

`ifdef HLS_DEADLOCK_REPORT_ALL_EN
  logic [NUM_MON-1:0] pend_q, pend_d, rep_q, rep_d, rep_nx, pend_nx;

  assign cand    = pend_q | (conf & ~rep_q);
  assign rep_nx  = rep_q | (NUM_MON'(1) << rpt_id_q);
  assign pend_nx = cand & ~rep_nx;

  always_comb begin
    pend_d = cand;
    rep_d  = rep_q;
    if (rpt_valid_q && bus.rpt_ready) begin
      pend_d = pend_nx;
      rep_d  = rep_nx;
    end
    if (clr_eff) begin
      pend_d = '0;
      rep_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      rep_q  <= '0;
    end else begin
      pend_q <= pend_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign cand = conf;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ts_q         <= '0;
      rpt_valid_q  <= 1'b0;
      rpt_id_q     <= '0;
      rpt_cycles_q <= '0;
      flag_q       <= 1'b0;
      for (int i = 0; i < NUM_MON; i++) cnt_q[i] <= '0;
    end else begin
      ts_q  <= ts_q + 1'b1;
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (|cand) begin
            state_q      <= S_REPORT;
            rpt_valid_q  <= 1'b1;
            rpt_id_q     <= lowest(cand);
            rpt_cycles_q <= ts_q;
            flag_q       <= 1'b1;
          end
        end
        S_REPORT: begin
          if (bus.rpt_ready) begin
`ifdef HLS_DEADLOCK_REPORT_ALL_EN
            if (|pend_nx) begin
              rpt_id_q     <= lowest(pend_nx);
              rpt_cycles_q <= ts_q;
            end else
`endif
            begin
              state_q     <= S_LATCHED;
              rpt_valid_q <= 1'b0;
            end
          end
        end
        S_LATCHED: begin
          if (bus.clear) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rpt_valid     = rpt_valid_q;
  assign bus.rpt_id        = rpt_id_q;
  assign bus.rpt_cycles    = rpt_cycles_q;
  assign bus.deadlock_flag = flag_q;
endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Randomized and directed bench for hls_deadlock_reporter with a queue-based scoreboard.
module tb_hls_deadlock_reporter;
  localparam int NM   = 4;
  localparam int IDW  = 2;
  localparam int HOLD = 4;
  localparam int CW   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hls_deadlock_reporter_if #(.NUM_MON(NM), .ID_W(IDW), .CNT_W(CW)) bus ();

  hls_deadlock_reporter #(
    .NUM_MON(NM), .ID_W(IDW), .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int id;
    int cyc;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  int   got_ids[$];
  int   last_cyc = -1;
  bit   running = 1'b0;

  // Reference: mode 0 = no deadlock, 1 = record outstanding, 2 = deadlock latched
  int m_mode, m_ts, m_cur, m_pend, m_rep;
  int m_streak[NM];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int lowest(input int m);
    for (int i = 0; i < NM; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ts = 0; m_cur = 0; m_pend = 0; m_rep = 0;
    for (int i = 0; i < NM; i++) m_streak[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input int m, input bit c, input bit r);
    int  conf, cand, old_mode;
    bit  clr_eff;
    conf = 0;
    for (int i = 0; i < NM; i++) if (m_streak[i] >= HOLD) conf |= (1 << i);
    old_mode = m_mode;
    clr_eff  = c && (old_mode != 1);
`ifdef HLS_DEADLOCK_REPORT_ALL_EN
    m_pend |= conf & ~m_rep;
    cand = m_pend;
`else
    cand = conf;
`endif
    case (old_mode)
      0: if (cand != 0) begin
           m_cur = lowest(cand);
           exp_q.push_back('{id: m_cur, cyc: m_ts});
           m_mode = 1;
         end
      1: if (r) begin
`ifdef HLS_DEADLOCK_REPORT_ALL_EN
           m_rep  |= (1 << m_cur);
           m_pend &= ~m_rep;
           if (m_pend != 0) begin
             m_cur = lowest(m_pend);
             exp_q.push_back('{id: m_cur, cyc: m_ts});
           end else m_mode = 2;
`else
           m_mode = 2;
`endif
         end
      default: if (c) m_mode = 0;
    endcase
    for (int i = 0; i < NM; i++)
      m_streak[i] = (clr_eff || !m[i]) ? 0 : ((m_streak[i] < HOLD) ? m_streak[i] + 1 : HOLD);
    if (clr_eff) begin
      m_pend = 0;
      m_rep  = 0;
    end
    m_ts = (m_ts + 1) % (1 << CW);
  endtask

  task automatic cycle(input logic [NM-1:0] m, input logic c, input logic r);
    bus.mon_block = m;
    bus.clear     = c;
    bus.rpt_ready = r;
    @(posedge clock);
    #2;
    model_step(int'(m), c, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mon_block = '0;
    bus.clear     = 1'b0;
    bus.rpt_ready = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compares the presented record against the scoreboard head, pops on handshake
  always @(negedge clock) begin
    if (running && !reset) begin
      chk("deadlock_flag", int'(bus.deadlock_flag), int'(m_mode != 0));
      chk("rpt_valid", int'(bus.rpt_valid), int'(m_mode == 1));
      if (bus.rpt_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report: id %0d cycles %0d, no record expected",
                   bus.rpt_id, bus.rpt_cycles);
        end else begin
          chk("rpt_id", int'(bus.rpt_id), exp_q[0].id);
          chk("rpt_cycles", int'(bus.rpt_cycles), exp_q[0].cyc);
          if (bus.rpt_ready) begin
            got_ids.push_back(int'(bus.rpt_id));
            last_cyc = int'(bus.rpt_cycles);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    int hold;
    logic [NM-1:0] pat;
    bus.mon_block = '0;
    bus.clear     = 1'b0;
    bus.rpt_ready = 1'b1;
    model_reset();
    running = 1'b1;

    do_reset();
    chk("reset_valid", int'(bus.rpt_valid), 0);
    chk("reset_id", int'(bus.rpt_id), 0);
    chk("reset_cycles", int'(bus.rpt_cycles), 0);
    chk("reset_flag", int'(bus.deadlock_flag), 0);

    // Monitor 2 blocks from cycle 10: confirmed in cycle 14, record in cycle 15
    repeat (10) cycle(4'b0000, 1'b0, 1'b1);
    repeat (6)  cycle(4'b0100, 1'b0, 1'b1);
    chk("s1_count", got_ids.size(), 1);
    chk("s1_id", got_ids[0], 2);
    chk("s1_cycles", last_cyc, 14);
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);

    // A one-cycle drop restarts the persistence count
    do_reset();
    n = got_ids.size();
    repeat (3) cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    repeat (3) cycle(4'b0010, 1'b0, 1'b1);
    repeat (5) cycle(4'b0000, 1'b0, 1'b1);
    chk("s2_no_report", got_ids.size(), n);
    chk("s2_flag", int'(bus.deadlock_flag), 0);

    // Simultaneous monitors 1 and 3: lowest index wins
    do_reset();
    n = got_ids.size();
    repeat (30) cycle(4'b1010, 1'b0, 1'b1);
`ifdef HLS_DEADLOCK_REPORT_ALL_EN
    chk("s3_count", got_ids.size(), n + 2);
    chk("s3_first_id", got_ids[n], 1);
    chk("s3_second_id", got_ids[n + 1], 3);
    repeat (2)  cycle(4'b0000, 1'b0, 1'b1);
    repeat (10) cycle(4'b0010, 1'b0, 1'b1);
    chk("s6_no_rereport", got_ids.size(), n + 2);
    cycle(4'b0010, 1'b1, 1'b1);
    repeat (HOLD + 3) cycle(4'b0010, 1'b0, 1'b1);
    chk("s6_after_clear", got_ids.size(), n + 3);
`else
    chk("s3_count", got_ids.size(), n + 1);
    chk("s3_first_id", got_ids[n], 1);
`endif

    // Backpressure: record held stable, one handshake, clear, re-block
    do_reset();
    n = got_ids.size();
    repeat (HOLD + 1 + 20) cycle(4'b0001, 1'b0, 1'b0);
    chk("s4_held_valid", int'(bus.rpt_valid), 1);
    chk("s4_held_cycles", int'(bus.rpt_cycles), HOLD);
    chk("s4_no_hs", got_ids.size(), n);
    repeat (4) cycle(4'b0001, 1'b0, 1'b1);
    chk("s4_one_hs", got_ids.size(), n + 1);
    cycle(4'b0000, 1'b1, 1'b1);
    chk("s4_flag_cleared", int'(bus.deadlock_flag), 0);
    repeat (HOLD + 3) cycle(4'b0001, 1'b0, 1'b1);
    chk("s4_rereport", got_ids.size(), n + 2);

    // Reset while a record is outstanding drops it
    do_reset();
    repeat (HOLD + 2) cycle(4'b0001, 1'b0, 1'b0);
    chk("rst_mid_valid_before", int'(bus.rpt_valid), 1);
    do_reset();
    chk("rst_mid_valid_after", int'(bus.rpt_valid), 0);

    // Randomized traffic checked by the scoreboard
    do_reset();
    hold = 0;
    pat  = '0;
    for (int k = 0; k < 2000; k++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0:       pat = '0;
          1, 2:    pat = 4'b0001 << $urandom_range(0, 3);
          default: pat = 4'($urandom);
        endcase
        hold = $urandom_range(1, 8);
      end
      hold--;
      cycle(pat, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0);
    end

    // Timestamp wrap: confirmation lands HOLD cycles after blocking starts at 0xFFFE
    do_reset();
    while (m_ts != 16'hFFFE) cycle(4'b0000, 1'b0, 1'b1);
    n = got_ids.size();
    repeat (HOLD + 3) cycle(4'b0001, 1'b0, 1'b1);
    chk("s5_count", got_ids.size(), n + 1);
    chk("s5_wrap_cycles", last_cyc, (16'hFFFE + HOLD) % (1 << CW));

    running = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
